pipe_skid_reg: RTL and testbench

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg_if.sv | 31 +++
 rtl/pipe_skid_reg.sv | 118 +++++++++++
 tb/tb_pipe_skid_reg.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_skid_reg_if.sv
// ============================================================================
// Module      : pipe_skid_reg_if
// Description : Handshake bundle for pipe_skid_reg (upstream, downstream, flush).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipe_skid_reg_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [1:0]       occupancy;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );
endinterface

`default_nettype wire

// File: rtl/pipe_skid_reg.sv
// ============================================================================
// Module      : pipe_skid_reg
// Description : Two-entry skid-buffered pipeline register with flush.
//               Optional stall counter enabled by macro PIPE_SKID_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_skid_reg #(
    parameter int WIDTH        = 32,
    parameter bit CLR_ON_FLUSH = 1'b1
) (
    input  wire logic         CLK,
    input  wire logic         RST,
    pipe_skid_reg_if.slave    bus
`ifdef PIPE_SKID_STATS_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             w_accept;
    logic             w_emit;

    // Handshake outputs come straight from the state register.
    assign bus.in_ready  = (state_q != ST_TWO);
    assign bus.out_valid = (state_q != ST_EMPTY);
    assign bus.out_data  = main_q;
    assign bus.occupancy = state_q;

    assign w_accept = bus.in_valid  && bus.in_ready;
    assign w_emit   = bus.out_valid && bus.out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (bus.flush) begin
            state_d = ST_EMPTY;
            if (CLR_ON_FLUSH) begin
                main_d = '0;
                skid_d = '0;
            end
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (w_accept) begin
                        state_d = ST_ONE;
                        main_d  = bus.in_data;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_emit) begin
                        main_d = bus.in_data;
                    end else if (w_accept) begin
                        state_d = ST_TWO;
                        skid_d  = bus.in_data;
                    end else if (w_emit) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_emit) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef PIPE_SKID_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating; flush deliberately leaves the count alone.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (bus.out_valid && !bus.out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
// ============================================================================
// Module      : tb_pipe_skid_reg
// Description : Scoreboard bench for pipe_skid_reg; queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_skid_reg;

    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_skid_reg_if #(.WIDTH(WIDTH)) bus ();
`ifdef PIPE_SKID_STATS_EN
    logic [31:0] stall_cnt;
`endif

    pipe_skid_reg #(.WIDTH(WIDTH), .CLR_ON_FLUSH(1'b1)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
`ifdef PIPE_SKID_STATS_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    int               errors = 0;
    int               checks = 0;
    logic [WIDTH-1:0] exp_q[$];
    bit               emit_seen = 1'b0;
    bit               last_accept;
    int               emitted = 0;
    logic [WIDTH-1:0] last_out;
    longint unsigned  stall_model = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT against the held-item queue and pops on emit.
    always @(negedge clk) begin
        if (!rst) begin
            chk("occupancy", 64'(bus.occupancy), 64'(exp_q.size()));
            chk("in_ready", 64'(bus.in_ready), 64'(exp_q.size() < 2));
            chk("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
`ifdef PIPE_SKID_STATS_EN
            chk("stall_cnt", 64'(stall_cnt), 64'(stall_model));
`endif
            if (exp_q.size() != 0) begin
                chk("out_data", 64'(bus.out_data), 64'(exp_q[0]));
                if (bus.out_ready) begin
                    last_out  = exp_q.pop_front();
                    emit_seen = 1'b1;
                    emitted++;
                end
            end
        end
    end

    // Drive one cycle of inputs, then update the model at the edge.
    task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic f);
        int occ_pre;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
        bus.flush     = f;
        @(posedge clk);
        occ_pre     = exp_q.size() + (emit_seen ? 1 : 0);
        last_accept = v && (occ_pre < 2);
        if ((occ_pre > 0) && !r && (stall_model != 64'hFFFF_FFFF)) stall_model++;
        if (f) exp_q.delete();
        else if (last_accept) exp_q.push_back(d);
        emit_seen = 1'b0;
        #1;
    endtask

    task automatic async_reset();
        rst = 1'b1;
        exp_q.delete();
        emit_seen   = 1'b0;
        stall_model = 0;
        #2;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        chk("rst_occupancy", 64'(bus.occupancy), 64'd0);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int next;
        int cyc;
        int base;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        #12;
        rst = 1'b0;
        #1;
        chk("init_in_ready", 64'(bus.in_ready), 64'd1);
        chk("init_out_valid", 64'(bus.out_valid), 64'd0);
        chk("init_out_data", 64'(bus.out_data), 64'd0);
        chk("init_occupancy", 64'(bus.occupancy), 64'd0);

`ifdef PIPE_SKID_STATS_EN
        step(1'b1, 32'h11, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("stats_after_7", 64'(stall_cnt), 64'd7);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("stats_after_flush", 64'(stall_cnt), 64'd7);
        async_reset();
        chk("stats_after_rst", 64'(stall_cnt), 64'd0);
`endif

        // Streaming
        step(1'b1, 32'h1, 1'b1, 1'b0);
        chk("stream_1", 64'(bus.out_data), 64'h1);
        step(1'b1, 32'h2, 1'b1, 1'b0);
        chk("stream_2", 64'(bus.out_data), 64'h2);
        chk("stream_ready", 64'(bus.in_ready), 64'd1);
        step(1'b1, 32'h3, 1'b1, 1'b0);
        chk("stream_3", 64'(bus.out_data), 64'h3);
        chk("stream_occ", 64'(bus.occupancy), 64'd1);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Backpressure
        step(1'b1, 32'hA, 1'b0, 1'b0);
        step(1'b1, 32'hB, 1'b0, 1'b0);
        chk("bp_occ", 64'(bus.occupancy), 64'd2);
        chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
        chk("bp_hold", 64'(bus.out_data), 64'hA);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("bp_second", 64'(bus.out_data), 64'hB);
        chk("bp_ready_back", 64'(bus.in_ready), 64'd1);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Flush with a same-cycle push that must be dropped
        step(1'b1, 32'hA, 1'b0, 1'b0);
        step(1'b1, 32'hB, 1'b0, 1'b0);
        step(1'b1, 32'hC, 1'b0, 1'b1);
        chk("flush_occ", 64'(bus.occupancy), 64'd0);
        chk("flush_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_data", 64'(bus.out_data), 64'd0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("flush_no_c", 64'(bus.out_valid), 64'd0);

        // Asynchronous reset while holding two entries
        step(1'b1, 32'hA, 1'b0, 1'b0);
        step(1'b1, 32'hB, 1'b0, 1'b0);
        async_reset();
        step(1'b1, 32'h5, 1'b1, 1'b0);
        chk("post_rst_valid", 64'(bus.out_valid), 64'd1);
        chk("post_rst_data", 64'(bus.out_data), 64'h5);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Ordering soak
        base = emitted;
        next = 0;
        cyc  = 0;
        while ((next < 1000) && (cyc < 20000)) begin
            step(1'($urandom_range(0, 3) != 0), 32'(next), 1'($urandom_range(0, 2) != 0), 1'b0);
            if (last_accept) next++;
            cyc++;
        end
        chk("soak_pushed", 64'(next), 64'd1000);
        cyc = 0;
        while (((exp_q.size() != 0) || bus.out_valid) && (cyc < 20)) begin
            step(1'b0, 32'h0, 1'b1, 1'b0);
            cyc++;
        end
        chk("soak_drained", 64'(exp_q.size()), 64'd0);
        chk("soak_count", 64'(emitted - base), 64'd1000);
        chk("soak_last", 64'(last_out), 64'd999);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
